nios_system_onchip_arb: RTL and testbench
=========================================

NIOS_SYSTEM_ONCHIP_ARB -- requirements
Module: nios_system_onchip_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, RAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width; the byteenable width SHALL be DATA_W/8.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have, for each requester port n in {0,1}, the following ports:
- sn_address, input, ADDR_W
- sn_byteenable, input, DATA_W/8
- sn_read, input, 1
- sn_write, input, 1
- sn_writedata, input, DATA_W
- sn_waitrequest, output, 1
- sn_readdata, output, DATA_W
- sn_readdatavalid, output, 1
REQ-006 The block SHALL have the RAM-side ports:
- ram_address, output, ADDR_W
- ram_byteenable, output, DATA_W/8
- ram_chipselect, output, 1
- ram_write, output, 1
- ram_writedata, output, DATA_W
- ram_clken, output, 1
- ram_readdata, input, DATA_W; the RAM registers its address and returns data one cycle later.

Function
REQ-007 A port SHALL be requesting when sn_read or sn_write is high; sn_read and sn_write both high SHALL be treated as a write.
REQ-008 Arbitration SHALL be combinational each cycle: at most one port is granted, and only a requesting port is granted.
REQ-009 With only one port requesting, that port SHALL be granted in the same cycle.
REQ-010 With both ports requesting, the port other than last_gnt SHALL be granted; last_gnt is a 1-bit register that updates on every grant.
REQ-011 The granted port SHALL see sn_waitrequest low, and its address, byteenable and writedata SHALL drive the RAM.
REQ-012 ram_chipselect SHALL be high, and ram_write SHALL equal the granted write, in the grant cycle.
REQ-013 A requesting port that is not granted SHALL see sn_waitrequest high and SHALL hold its command.
REQ-014 A non-requesting port SHALL see sn_waitrequest low.
REQ-015 With no grant, ram_chipselect and ram_write SHALL be low.
REQ-016 ram_address, ram_byteenable and ram_writedata SHALL hold their last values when there is no grant.
REQ-017 A granted read SHALL set a registered pending flag and owner tag.
REQ-018 In the following cycle, the owner's sn_readdatavalid SHALL pulse high for one cycle, with sn_readdata = ram_readdata. Read latency is exactly 1 cycle after the grant.
REQ-019 Back-to-back reads SHALL be fully pipelined: one grant per cycle, and returns are in grant order.
REQ-020 sn_readdata SHALL be driven from ram_readdata on both ports; only readdatavalid is qualified.
REQ-021 A write SHALL complete in its grant cycle and SHALL generate no readdatavalid.
REQ-022 A read and a write to the same address in consecutive cycles SHALL be serviced in grant order; a read after a write SHALL return the new data.
REQ-023 ram_clken SHALL be constant 1.

Reset
REQ-024 While reset is high, both sn_waitrequest SHALL be high.
REQ-025 While reset is high, ram_chipselect and ram_write SHALL be low.
REQ-026 While reset is high, both sn_readdatavalid, the pending flag, the owner tag and last_gnt SHALL be 0.
REQ-027 A read granted in the cycle reset asserts SHALL be dropped, and no readdatavalid SHALL follow it.
REQ-028 The first cycle after reset deassertion SHALL arbitrate normally, with last_gnt = 0, so port 1 wins a tie.

Configuration
REQ-029 With macro ONCHIP_ARB_RR_EN defined, arbitration SHALL be round-robin per REQ-010.
REQ-030 Without ONCHIP_ARB_RR_EN, port 0 SHALL always win a tie; last_gnt SHALL be absent and port 1 may starve.

Structure
REQ-031 A shared package nios_system_onchip_arb_pkg SHALL hold:
- the default ADDR_W and DATA_W constants
- the 1-bit port-id typedef
- the grant-decision typedef
REQ-032 Arbitration SHALL be one sub-module, nios_system_onchip_arb_sel: inputs req[1:0] and last_gnt; outputs gnt[1:0] one-hot-or-zero; purely combinational.
REQ-033 The read-return tracking and muxing SHALL live in the top module.

Verification
REQ-034 Reset: hold reset 3 cycles with both ports reading -> both waitrequest high, ram_chipselect 0, no readdatavalid during reset or the cycle after.
REQ-035 Single read: s0 reads address 0x010 where RAM holds 0xDEADBEEF -> s0_waitrequest 0 that cycle, s0_readdatavalid 1 next cycle with 0xDEADBEEF, s1_readdatavalid stays 0.
REQ-036 Contention: both ports continuously read (s0 at 0x001, s1 at 0x002) for 6 cycles with RR enabled -> grants alternate 1,0,1,0,1,0 and each readdatavalid pulses 3 times at the correct port.
REQ-037 Write then read: s1 writes 0x12345678 with byteenable 0x3 to 0x0FF over 0xFFFFFFFF, then s0 reads 0x0FF -> s0_readdata = 0xFFFF5678 one cycle after the read grant.
REQ-038 Fixed priority: build without ONCHIP_ARB_RR_EN and both ports request for 4 cycles -> s0 granted all 4 cycles, s1_waitrequest high throughout.
REQ-039 Reset mid-read: assert reset in s0's read grant cycle -> no s0_readdatavalid in the next cycle.

Source files
------------

// File: rtl/nios_system_onchip_arb_pkg.sv
// Shared types and defaults for the two-port on-chip RAM arbiter.
// Optional feature macro: ONCHIP_ARB_RR_EN (round-robin tie-break).
package nios_system_onchip_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 32;

  // Identifies one of the two requester ports.
  typedef logic port_id_t;

  // Decoded arbitration result: whether anyone won, and who.
  typedef struct packed {
    logic     valid;
    port_id_t id;
  } gnt_dec_t;

  // Turn a one-hot-or-zero grant vector into a decision record.
  function automatic gnt_dec_t decode_gnt(input logic [1:0] gnt);
    gnt_dec_t d;
    d.valid = |gnt;
    d.id    = port_id_t'(gnt[1]);
    return d;
  endfunction

endpackage

// File: rtl/nios_system_onchip_arb_sel.sv
// Combinational two-way arbiter: a lone requester wins; on a tie the
// port that did not win last time is chosen.
module nios_system_onchip_arb_sel
  import nios_system_onchip_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last_gnt,
  output logic [1:0] gnt
);

  // Pick at most one requesting port.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == 1'b1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/nios_system_onchip_arb.sv
// Two-port arbiter in front of a single-port on-chip RAM with 1-cycle
// registered read latency. Define ONCHIP_ARB_RR_EN for round-robin tie
// breaking; otherwise port 0 always wins a tie.
module nios_system_onchip_arb
  import nios_system_onchip_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     s0_address,
  input  logic [DATA_W/8-1:0]   s0_byteenable,
  input  logic                  s0_read,
  input  logic                  s0_write,
  input  logic [DATA_W-1:0]     s0_writedata,
  output logic                  s0_waitrequest,
  output logic [DATA_W-1:0]     s0_readdata,
  output logic                  s0_readdatavalid,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_W-1:0]     s1_writedata,
  output logic                  s1_waitrequest,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic                  ram_clken,
  input  logic [DATA_W-1:0]     ram_readdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic [1:0]        req;
  logic [1:0]        req_arb;
  logic [1:0]        gnt;
  gnt_dec_t          dec;
  port_id_t          last_gnt;
  logic [ADDR_W-1:0] cmd_address;
  logic [BE_W-1:0]   cmd_byteenable;
  logic [DATA_W-1:0] cmd_writedata;
  logic              cmd_write;
  logic [ADDR_W-1:0] hold_address;
  logic [BE_W-1:0]   hold_byteenable;
  logic [DATA_W-1:0] hold_writedata;
  logic              rd_gnt;
  logic              pending;
  port_id_t          owner;

  // Read+write together counts as a write; reset blocks all grants.
  assign req     = {s1_read | s1_write, s0_read | s0_write};
  assign req_arb = reset ? 2'b00 : req;

  nios_system_onchip_arb_sel u_sel (
    .req      (req_arb),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  assign dec = decode_gnt(gnt);

  // Select the winning port's command.
  always_comb begin
    cmd_address    = s0_address;
    cmd_byteenable = s0_byteenable;
    cmd_writedata  = s0_writedata;
    cmd_write      = s0_write;
    if (dec.id == 1'b1) begin
      cmd_address    = s1_address;
      cmd_byteenable = s1_byteenable;
      cmd_writedata  = s1_writedata;
      cmd_write      = s1_write;
    end
  end

  assign rd_gnt = dec.valid & ~cmd_write;

  // Remember the last granted command so the RAM bus is stable when idle.
  always_ff @(posedge clk) begin
    if (dec.valid) begin
      hold_address    <= cmd_address;
      hold_byteenable <= cmd_byteenable;
      hold_writedata  <= cmd_writedata;
    end
  end

  assign ram_address    = dec.valid ? cmd_address    : hold_address;
  assign ram_byteenable = dec.valid ? cmd_byteenable : hold_byteenable;
  assign ram_writedata  = dec.valid ? cmd_writedata  : hold_writedata;
  assign ram_chipselect = dec.valid;
  assign ram_write      = dec.valid & cmd_write;
  assign ram_clken      = 1'b1;

  assign s0_waitrequest = reset | (req[0] & ~gnt[0]);
  assign s1_waitrequest = reset | (req[1] & ~gnt[1]);

`ifdef ONCHIP_ARB_RR_EN
  // Track the most recent winner for round-robin tie breaking.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= 1'b0;
    end else if (dec.valid) begin
      last_gnt <= dec.id;
    end
  end
`else
  // Pinning the previous winner to port 1 makes port 0 win every tie.
  assign last_gnt = port_id_t'(1'b1);
`endif

  // One-deep read-return tracker: the RAM answers the cycle after a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      owner   <= 1'b0;
    end else begin
      pending <= rd_gnt;
      if (rd_gnt) begin
        owner <= dec.id;
      end
    end
  end

  assign s0_readdata      = ram_readdata;
  assign s1_readdata      = ram_readdata;
  assign s0_readdatavalid = pending & (owner == 1'b0);
  assign s1_readdatavalid = pending & (owner == 1'b1);

endmodule

// File: tb/tb_nios_system_onchip_arb.sv
// Self-checking bench for nios_system_onchip_arb: directed scenarios plus
// randomized traffic against a behavioural model of the arbiter and RAM.
module tb_nios_system_onchip_arb;

  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = DW / 8;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef ONCHIP_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [AW-1:0] s0_address, s1_address;
  logic [BW-1:0] s0_byteenable, s1_byteenable;
  logic          s0_read, s0_write, s1_read, s1_write;
  logic [DW-1:0] s0_writedata, s1_writedata;
  logic          s0_waitrequest, s1_waitrequest;
  logic [DW-1:0] s0_readdata, s1_readdata;
  logic          s0_readdatavalid, s1_readdatavalid;
  logic [AW-1:0] ram_address;
  logic [BW-1:0] ram_byteenable;
  logic          ram_chipselect, ram_write, ram_clken;
  logic [DW-1:0] ram_writedata;
  logic [DW-1:0] ram_readdata;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  // Reference model state
  bit            m_pend = 1'b0;
  bit            m_own  = 1'b0;
  logic [DW-1:0] m_data;
  bit            m_last = 1'b0;
  bit            m_wait0 = 1'b0, m_wait1 = 1'b0;
  bit            have_hold = 1'b0;
  logic [AW-1:0] h_addr;
  logic [BW-1:0] h_be;
  logic [DW-1:0] h_wd;

  // Observations kept for directed checks
  bit            obs_rv0, obs_rv1;
  logic [DW-1:0] obs_rd0;
  int            obs_gid;
  int            rv_cnt0, rv_cnt1;

  nios_system_onchip_arb dut (
    .clk              (clk),
    .reset            (reset),
    .s0_address       (s0_address),
    .s0_byteenable    (s0_byteenable),
    .s0_read          (s0_read),
    .s0_write         (s0_write),
    .s0_writedata     (s0_writedata),
    .s0_waitrequest   (s0_waitrequest),
    .s0_readdata      (s0_readdata),
    .s0_readdatavalid (s0_readdatavalid),
    .s1_address       (s1_address),
    .s1_byteenable    (s1_byteenable),
    .s1_read          (s1_read),
    .s1_write         (s1_write),
    .s1_writedata     (s1_writedata),
    .s1_waitrequest   (s1_waitrequest),
    .s1_readdata      (s1_readdata),
    .s1_readdatavalid (s1_readdatavalid),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_writedata    (ram_writedata),
    .ram_clken        (ram_clken),
    .ram_readdata     (ram_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // On-chip RAM: registered address, data back one cycle later.
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < int'(BW); b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] = ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < int'(BW); b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already applied just after a falling edge.
  task automatic cycle();
    bit r0, r1, g_v, g_id, g_wr, e_w0, e_w1;
    logic [AW-1:0] g_a;
    logic [BW-1:0] g_be;
    logic [DW-1:0] g_wd;
    r0   = s0_read | s0_write;
    r1   = s1_read | s1_write;
    g_v  = !reset && (r0 || r1);
    if (r0 && r1) g_id = RR ? !m_last : 1'b0;
    else          g_id = r1;
    g_wr = g_id ? s1_write : s0_write;
    g_a  = g_id ? s1_address : s0_address;
    g_be = g_id ? s1_byteenable : s0_byteenable;
    g_wd = g_id ? s1_writedata : s0_writedata;
    e_w0 = reset || (r0 && !(g_v && !g_id));
    e_w1 = reset || (r1 && !(g_v && g_id));
    #1;
    chk("s0_waitrequest", 32'(s0_waitrequest), 32'(e_w0));
    chk("s1_waitrequest", 32'(s1_waitrequest), 32'(e_w1));
    chk("ram_chipselect", 32'(ram_chipselect), 32'(g_v));
    chk("ram_write", 32'(ram_write), 32'(g_v && g_wr));
    chk("ram_clken", 32'(ram_clken), 32'd1);
    if (g_v) begin
      chk("ram_address", 32'(ram_address), 32'(g_a));
      chk("ram_byteenable", 32'(ram_byteenable), 32'(g_be));
      chk("ram_writedata", ram_writedata, g_wd);
    end else if (have_hold) begin
      chk("ram_address_hold", 32'(ram_address), 32'(h_addr));
      chk("ram_byteenable_hold", 32'(ram_byteenable), 32'(h_be));
      chk("ram_writedata_hold", ram_writedata, h_wd);
    end
    chk("s0_readdatavalid", 32'(s0_readdatavalid), 32'(m_pend && !m_own));
    chk("s1_readdatavalid", 32'(s1_readdatavalid), 32'(m_pend && m_own));
    if (m_pend) begin
      chk("s0_readdata", s0_readdata, m_data);
      chk("s1_readdata", s1_readdata, m_data);
    end
    obs_rv0 = s0_readdatavalid;
    obs_rv1 = s1_readdatavalid;
    obs_rd0 = s0_readdata;
    if (r0 && !s0_waitrequest)      obs_gid = 0;
    else if (r1 && !s1_waitrequest) obs_gid = 1;
    else                            obs_gid = -1;
    rv_cnt0 += int'(s0_readdatavalid);
    rv_cnt1 += int'(s1_readdatavalid);
    m_wait0 = r0 && e_w0;
    m_wait1 = r1 && e_w1;
    @(posedge clk);
    if (reset) begin
      m_pend = 1'b0;
      m_own  = 1'b0;
      m_last = 1'b0;
    end else begin
      m_pend = g_v && !g_wr;
      if (m_pend) begin
        m_own  = g_id;
        m_data = ref_mem[g_a];
      end
      if (g_v) begin
        m_last    = g_id;
        have_hold = 1'b1;
        h_addr    = g_a;
        h_be      = g_be;
        h_wd      = g_wd;
        if (g_wr) ref_mem[g_a] = merge(ref_mem[g_a], g_wd, g_be);
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_cmd(output logic rd, output logic wr, output logic [AW-1:0] a,
                          output logic [BW-1:0] be, output logic [DW-1:0] wd);
    int op;
    op = int'($urandom_range(0, 4));
    rd = (op == 1) || (op == 3);
    wr = (op == 2) || (op == 3);
    a  = AW'($urandom_range(0, 15));
    be = BW'($urandom);
    wd = $urandom;
  endtask

  task automatic idle_ports();
    s0_read = 1'b0; s0_write = 1'b0;
    s1_read = 1'b0; s1_write = 1'b0;
  endtask

  int exp_gid[6];
  int exp_cnt0, exp_cnt1;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[12'h010] = 32'hDEADBEEF; ref_mem[12'h010] = 32'hDEADBEEF;
    mem[12'h0FF] = 32'hFFFFFFFF; ref_mem[12'h0FF] = 32'hFFFFFFFF;

    if (RR) begin
      exp_gid  = '{1, 0, 1, 0, 1, 0};
      exp_cnt0 = 3; exp_cnt1 = 3;
    end else begin
      exp_gid  = '{0, 0, 0, 0, 0, 0};
      exp_cnt0 = 6; exp_cnt1 = 0;
    end

    // Reset held with both ports reading
    reset = 1'b1;
    s0_address = 12'h001; s0_byteenable = '1; s0_writedata = '0;
    s1_address = 12'h002; s1_byteenable = '1; s1_writedata = '0;
    s0_read = 1'b1; s0_write = 1'b0;
    s1_read = 1'b1; s1_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle();

    // Contention straight out of reset
    reset   = 1'b0;
    rv_cnt0 = 0;
    rv_cnt1 = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk($sformatf("contention_gnt%0d", i), 32'(obs_gid), 32'(exp_gid[i]));
      if (i == 0) chk("rv_after_reset", 32'(obs_rv0 | obs_rv1), 32'd0);
    end
    idle_ports();
    cycle();
    chk("contention_rv_cnt0", 32'(rv_cnt0), 32'(exp_cnt0));
    chk("contention_rv_cnt1", 32'(rv_cnt1), 32'(exp_cnt1));

    // Single read from s0
    s0_read = 1'b1; s0_address = 12'h010;
    cycle();
    chk("single_rd_gnt", 32'(obs_gid), 32'd0);
    idle_ports();
    cycle();
    chk("single_rd_valid0", 32'(obs_rv0), 32'd1);
    chk("single_rd_valid1", 32'(obs_rv1), 32'd0);
    chk("single_rd_data", obs_rd0, 32'hDEADBEEF);

    // Byte-masked write from s1, then read back on s0
    s1_write = 1'b1; s1_address = 12'h0FF; s1_byteenable = 4'h3;
    s1_writedata = 32'h12345678;
    cycle();
    idle_ports();
    s0_read = 1'b1; s0_address = 12'h0FF;
    cycle();
    idle_ports();
    cycle();
    chk("wr_rd_valid", 32'(obs_rv0), 32'd1);
    chk("wr_rd_data", obs_rd0, 32'hFFFF5678);

    // Reset lands on the cycle s0 would be granted a read
    s0_read = 1'b1; s0_address = 12'h010;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle_ports();
    cycle();
    chk("rst_mid_rd_valid", 32'(obs_rv0), 32'd0);

    // Randomized traffic; a stalled port holds its command
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      if (!m_wait0) rand_cmd(s0_read, s0_write, s0_address, s0_byteenable, s0_writedata);
      if (!m_wait1) rand_cmd(s1_read, s1_write, s1_address, s1_byteenable, s1_writedata);
      cycle();
    end
    reset = 1'b0;
    idle_ports();
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
